// File: rtl/pe_conv_mac_buffer_in_slicer_if.sv
// Handshake bundle for the conv MAC input slicer: full-vector load side plus slice stream side.
// master = vector source / slice consumer, slave = the slicer itself.
interface pe_conv_mac_buffer_in_slicer_if #(
  parameter int pDATA_WIDTH     = 8,
  parameter int pIN_CHANNEL     = 32,
  parameter int pINPUT_PARALLEL = 8
);
  localparam int NUM_SLICE = pIN_CHANNEL / pINPUT_PARALLEL;
  localparam int IDX_W     = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1;

  logic                                   in_valid;
  logic                                   in_ready;
  logic [pDATA_WIDTH*pIN_CHANNEL-1:0]     data_in;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [pDATA_WIDTH*pINPUT_PARALLEL-1:0] data_out;
  logic [IDX_W-1:0]                       slice_idx;
  logic                                   last;
  logic                                   busy;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, slice_idx, last, busy
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, slice_idx, last, busy
  );
endinterface

// File: rtl/pe_conv_mac_buffer_in_slicer.sv
// Takes one packed channel vector and streams it out as NUM_SLICE narrower slices in channel order.
// Define PE_BUF_IN_PREFETCH_EN to add a pending-vector register that removes the inter-vector bubble.
module pe_conv_mac_buffer_in_slicer #(
  parameter int pDATA_WIDTH     = 8,
  parameter int pIN_CHANNEL     = 32,
  parameter int pINPUT_PARALLEL = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  pe_conv_mac_buffer_in_slicer_if.slave   bus
);
  localparam int NUM_SLICE = pIN_CHANNEL / pINPUT_PARALLEL;
  localparam int IDX_W     = (NUM_SLICE > 1) ? $clog2(NUM_SLICE) : 1;
  localparam int SLICE_W   = pDATA_WIDTH * pINPUT_PARALLEL;
  localparam int VEC_W     = pDATA_WIDTH * pIN_CHANNEL;
  localparam int MUX_N     = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICE - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]       r_state, w_state_next;
  logic [VEC_W-1:0] r_vec, w_vec_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic             r_in_ready, w_in_ready_next;
  logic             w_out_valid, w_load, w_take, w_wrap;
  logic [SLICE_W-1:0] w_slice [MUX_N];

`ifdef PE_BUF_IN_PREFETCH_EN
  logic [VEC_W-1:0] r_pend, w_pend_next;
  logic             r_pend_valid, w_pend_valid_next;
`endif

  // Mux table padded to a power of two so any idx value selects a defined entry.
  genvar gi;
  generate
    for (gi = 0; gi < MUX_N; gi++) begin : g_slice
      if (gi < NUM_SLICE) begin : g_real
        assign w_slice[gi] = r_vec[gi*SLICE_W +: SLICE_W];
      end else begin : g_pad
        assign w_slice[gi] = '0;
      end
    end
  endgenerate

  assign w_out_valid = (r_state == ST_STREAM);
  assign w_load      = bus.in_valid && r_in_ready;
  assign w_take      = w_out_valid && bus.out_ready;
  assign w_wrap      = w_take && (r_idx == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    w_vec_next   = r_vec;
    w_idx_next   = r_idx;
`ifdef PE_BUF_IN_PREFETCH_EN
    w_pend_next       = r_pend;
    w_pend_valid_next = r_pend_valid;
`endif
    if (r_state == ST_IDLE) begin
      if (w_load) begin
        w_vec_next   = bus.data_in;
        w_idx_next   = '0;
        w_state_next = ST_STREAM;
      end
    end else begin
      if (w_take && !w_wrap) begin
        w_idx_next = r_idx + 1'b1;
      end else if (w_wrap) begin
        w_idx_next = '0;
`ifdef PE_BUF_IN_PREFETCH_EN
        // A load can only coincide with the wrap when the pending slot is empty.
        if (r_pend_valid) begin
          w_vec_next        = r_pend;
          w_pend_valid_next = 1'b0;
        end else if (w_load) begin
          w_vec_next = bus.data_in;
        end else begin
          w_state_next = ST_IDLE;
        end
`else
        w_state_next = ST_IDLE;
`endif
      end
`ifdef PE_BUF_IN_PREFETCH_EN
      if (w_load && !w_wrap) begin
        w_pend_next       = bus.data_in;
        w_pend_valid_next = 1'b1;
      end
`endif
    end
  end

`ifdef PE_BUF_IN_PREFETCH_EN
  assign w_in_ready_next = !w_pend_valid_next;
`else
  assign w_in_ready_next = (w_state_next == ST_IDLE);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_vec      <= '0;
      r_idx      <= '0;
      r_in_ready <= 1'b0;
`ifdef PE_BUF_IN_PREFETCH_EN
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_vec      <= w_vec_next;
      r_idx      <= w_idx_next;
      r_in_ready <= w_in_ready_next;
`ifdef PE_BUF_IN_PREFETCH_EN
      r_pend       <= w_pend_next;
      r_pend_valid <= w_pend_valid_next;
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.data_out  = w_slice[r_idx];
  assign bus.slice_idx = r_idx;
  assign bus.last      = w_out_valid && (r_idx == LAST_IDX);
`ifdef PE_BUF_IN_PREFETCH_EN
  assign bus.busy      = w_out_valid || r_pend_valid;
`else
  assign bus.busy      = w_out_valid;
`endif
endmodule

// File: tb/tb_pe_conv_mac_buffer_in_slicer.sv
// Bench for the input slicer: a slice-queue model checks every cycle's outputs and handshakes.
module tb_pe_conv_mac_buffer_in_slicer;
  localparam int DW = 8;
  localparam int CH = 32;
  localparam int PAR = 8;
  localparam int NS = CH / PAR;
  localparam int SW = DW * PAR;
  localparam int VW = DW * CH;
`ifdef PE_BUF_IN_PREFETCH_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_conv_mac_buffer_in_slicer_if #(.pDATA_WIDTH(DW), .pIN_CHANNEL(CH), .pINPUT_PARALLEL(PAR)) bus ();

  pe_conv_mac_buffer_in_slicer #(.pDATA_WIDTH(DW), .pIN_CHANNEL(CH), .pINPUT_PARALLEL(PAR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_out_acc = 0;
  int n_zero = 0;
  bit in_acc = 1'b0;
  logic [SW-1:0] q_data [$];
  int            q_idx  [$];

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [VW-1:0] fill_vec(input logic [7:0] b);
    logic [VW-1:0] v;
    for (int c = 0; c < CH; c++) v[c*DW +: DW] = b;
    return v;
  endfunction

  // One clock: record handshakes before the edge, update the model, then check outputs after it.
  task automatic step();
    bit            pre_in, pre_out;
    logic [VW-1:0] pre_vec;
    bit            exp_rdy;
    pre_in  = bus.in_valid && bus.in_ready;
    pre_out = bus.out_valid && bus.out_ready;
    pre_vec = bus.data_in;
    @(posedge clk);
    #1;
    in_acc = pre_in;
    if (pre_out) begin
      n_out_acc++;
      if (q_data.size() == 0) check("spurious_slice", SW'(pre_out), '0);
      else begin
        void'(q_data.pop_front());
        void'(q_idx.pop_front());
      end
    end
    if (pre_in) begin
      for (int i = 0; i < NS; i++) begin
        q_data.push_back(pre_vec[i*SW +: SW]);
        q_idx.push_back(i);
      end
    end
    check("out_valid", SW'(bus.out_valid), SW'(q_data.size() != 0));
    check("busy", SW'(bus.busy), SW'(q_data.size() != 0));
    if (rst) begin
      exp_rdy = PRE ? (q_data.size() <= NS) : (q_data.size() == 0);
      check("in_ready", SW'(bus.in_ready), SW'(exp_rdy));
    end
    if (q_data.size() != 0) begin
      check("data_out", bus.data_out, q_data[0]);
      check("slice_idx", SW'(bus.slice_idx), SW'(q_idx[0]));
      check("last", SW'(bus.last), SW'(q_idx[0] == NS - 1));
    end
    if (!bus.out_valid) n_zero++;
  endtask

  task automatic load(input logic [VW-1:0] v, input bit keep, output int n);
    bus.in_valid = 1'b1;
    bus.data_in  = v;
    n = 0;
    do begin
      step();
      n++;
    end while (!in_acc && n < 64);
    check("load_accepted", SW'(in_acc), SW'(1));
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain(output int n);
    bus.out_ready = 1'b1;
    n = 0;
    while (q_data.size() != 0 && n < 64) begin
      step();
      n++;
    end
    check("drained", SW'(q_data.size()), '0);
  endtask

  initial begin
    logic [VW-1:0] v_cnt;
    int n, acc0;

    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < CH; c++) v_cnt[c*DW +: DW] = 8'(c);

    // 1: reset state, then in_ready one edge after release
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", SW'(bus.in_ready), '0);
    check("rst_out_valid", SW'(bus.out_valid), '0);
    check("rst_data_out", bus.data_out, '0);
    check("rst_slice_idx", SW'(bus.slice_idx), '0);
    check("rst_last", SW'(bus.last), '0);
    check("rst_busy", SW'(bus.busy), '0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    step();
    check("in_ready_after_release", SW'(bus.in_ready), SW'(1));

    // 2: counting-byte vector streamed with out_ready held high
    bus.out_ready = 1'b1;
    load(v_cnt, 1'b0, n);
    check("first_slice_const", bus.data_out, 64'h0706050403020100);
    drain(n);
    check("stream_cycles", SW'(n), SW'(NS));

    // 3: out_ready pattern 1,0,0 repeating
    bus.out_ready = 1'b0;
    load(v_cnt, 1'b0, n);
    acc0 = n_out_acc;
    for (int k = 0; k < 40 && q_data.size() != 0; k++) begin
      bus.out_ready = (k % 3 == 0);
      step();
    end
    check("stall_accepts", SW'(n_out_acc - acc0), SW'(NS));
    step();

    // 4: back-to-back A then B with in_valid held
    bus.out_ready = 1'b1;
    load(fill_vec(8'hAA), 1'b1, n);
    n_zero = 0;
    load(fill_vec(8'h55), 1'b0, n);
    check("b_accept_steps", SW'(n), PRE ? SW'(1) : SW'(NS + 1));
    drain(n);
    check("bubbles", SW'(n_zero), PRE ? SW'(1) : SW'(2));

    // 5: reset while slice 2 is on the output
    bus.out_ready = 1'b1;
    load(rand_vec(), 1'b0, n);
    step();
    step();
    check("at_slice2", SW'(bus.slice_idx), SW'(2));
    #2 rst = 1'b0;
    #1;
    check("midrst_out_valid", SW'(bus.out_valid), '0);
    check("midrst_in_ready", SW'(bus.in_ready), '0);
    check("midrst_data_out", bus.data_out, '0);
    q_data.delete();
    q_idx.delete();
    step();
    step();
    #2 rst = 1'b1;
    step();
    load(rand_vec(), 1'b0, n);
    check("restart_idx", SW'(bus.slice_idx), '0);
    drain(n);

    // 6: in_valid pulse during streaming
    bus.out_ready = 1'b1;
    acc0 = n_out_acc;
    load(rand_vec(), 1'b0, n);
    step();
    bus.in_valid = 1'b1;
    bus.data_in  = rand_vec();
    step();
    bus.in_valid = 1'b0;
    drain(n);
    repeat (3) step();
    check("pulse_slices", SW'(n_out_acc - acc0), PRE ? SW'(2 * NS) : SW'(NS));

    // Random traffic on both sides; data only changes when not offered or just accepted
    for (int k = 0; k < 400; k++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid || in_acc) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.data_in  = rand_vec();
      end
      step();
    end
    bus.in_valid = 1'b0;
    drain(n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pe_conv_mac_buffer_in_slicer.md
Name: pe_conv_mac_buffer_in_slicer

Overview:
- Reader-side counterpart of the conv1 MAC output gather buffer.
- Accepts one full-width channel vector (pIN_CHANNEL × pDATA_WIDTH) per handshake.
- Streams the vector out as pIN_CHANNEL/pINPUT_PARALLEL slices, one slice per output handshake, in channel order.
- Sits between a conv layer's packed output and the next PE's narrower MAC input port.

Parameters:
- pDATA_WIDTH, 8, bits per channel element.
- pIN_CHANNEL, 32, channels in one full input vector.
- pINPUT_PARALLEL, 8, channels per output slice. Must divide pIN_CHANNEL; NUM_SLICE = pIN_CHANNEL/pINPUT_PARALLEL.
- Derived IDX_W = max(1, $clog2(NUM_SLICE)).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  data_in holds a full vector.
- in_ready  out  1  slicer can take a vector.
- data_in  in  pDATA_WIDTH*pIN_CHANNEL  packed vector; channel c at bits [c*pDATA_WIDTH +: pDATA_WIDTH].
- out_valid  out  1  data_out holds a valid slice.
- out_ready  in  1  consumer takes the slice.
- data_out  out  pDATA_WIDTH*pINPUT_PARALLEL  current slice; slice i = channels [i*pINPUT_PARALLEL +: pINPUT_PARALLEL].
- slice_idx  out  IDX_W  index of the slice on data_out.
- last  out  1  high when slice_idx == NUM_SLICE-1 and out_valid.
- busy  out  1  high while a vector is held (state STREAM).

Behaviour:
- While rst is low (asynchronous): state=IDLE, vector reg=0, idx=0.
  - Outputs during reset: in_ready=0, out_valid=0, data_out=0, slice_idx=0, last=0, busy=0.
- in_ready is registered and rises at the first posedge after rst deasserts.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture data_in, set idx=0, go to STREAM, drop in_ready (next cycle).
  - STREAM: out_valid=1, data_out = vector[idx], slice_idx=idx.
    - On out_valid&&out_ready with idx<NUM_SLICE-1: idx+1.
    - On out_valid&&out_ready with idx==NUM_SLICE-1: go to IDLE, idx=0, in_ready=1 next cycle.
- Latency: first slice valid the cycle after the load handshake.
- Throughput without the optional feature: NUM_SLICE+1 cycles per vector (one bubble).
- Output stall: out_valid high with out_ready low holds data_out, slice_idx and last stable. No slice is dropped or repeated.
- in_valid in STREAM is ignored (in_ready=0). The source must hold its data.
- NUM_SLICE==1: every slice is last; idx stays 0.
- data_out is driven from registers (vector reg + idx). There is no combinational path from data_in to data_out.
- Reset mid-stream: the vector is discarded; out_valid drops immediately (async); restart in IDLE.

Optional Feature:
- Macro PE_BUF_IN_PREFETCH_EN.
- Defined:
  - Adds a pending vector register with a pend_valid flag.
  - in_ready = !pend_valid (registered), so a load can be accepted during STREAM.
  - Last-slice accept with pend_valid: the pending vector moves to active, idx=0, out_valid stays 1 (no bubble).
  - Last-slice accept in the same cycle as a load with pend empty: data_in loads straight into active (no bubble).
  - Throughput: NUM_SLICE cycles per vector. busy is high while either register is valid.
- Undefined: pending register absent; behaviour exactly as in Behaviour.

Test Plan (pDATA_WIDTH=8, pIN_CHANNEL=32, pINPUT_PARALLEL=8, NUM_SLICE=4):
1. Reset then idle: in_ready=0 during reset, in_ready=1 one cycle after release; out_valid=0.
2. Load a vector with byte c = c (0x00..0x1F), out_ready=1:
   - Slices 0x0706050403020100, 0x0F0E..08, 0x1716..10, 0x1F1E..18 on 4 consecutive cycles.
   - slice_idx 0..3; last only on slice 3.
3. Same load, out_ready toggling 1,0,0,1,...: each slice holds stable while out_ready=0. Exactly 4 accepted slices, in order.
4. Back-to-back loads A (all 0xAA) then B (all 0x55) with in_valid held high:
   - Without macro: 1 bubble between A slice 3 and B slice 0.
   - With PE_BUF_IN_PREFETCH_EN: B slice 0 follows A slice 3 directly, and B is accepted while A streams.
5. Assert rst during slice 2 of a vector: out_valid=0 at once. After release, the next load streams from slice 0 with the new data. No stale slice appears.
6. in_valid pulsed in STREAM without the macro: ignored. The vector in flight is unchanged and the pulse produces no extra slices.
